botoes_event_encoder: RTL and testbench

BOTOES_EVENT_ENCODER -- requirements
Module: botoes_event_encoder

---
 rtl/botoes_pkg.sv | 16 +
 rtl/botoes_event_fifo.sv | 55 +++++
 rtl/botoes_event_encoder.sv | 117 +++++++++++
 tb/tb_botoes_event_encoder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/botoes_pkg.sv
// Shared definitions for the button event encoder.
//   NumBotoesDefault : default number of debounced button lines
//   IdxWDefault      : index width for the default button count
//   idx_width()      : index width for an arbitrary button count
package botoes_pkg;

  localparam int unsigned NumBotoesDefault = 13;

  // $clog2 collapses to 0 for a single line; keep at least one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IdxWDefault = $clog2(NumBotoesDefault);

endpackage

// File: rtl/botoes_event_fifo.sv
// Synchronous FIFO holding button indices.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   push, push_data : write request and data
//   pop, pop_data   : read request and head data (head is combinational)
//   full, empty     : occupancy flags
// Pointers carry one extra wrap bit: equal pointers mean empty, equal low bits
// with differing wrap bits mean full. Push while full is accepted only together
// with a pop, leaving occupancy unchanged.
module botoes_event_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem_q[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

endmodule

// File: rtl/botoes_event_encoder.sv
// Turns debounced button levels into a queue of press events (button indices).
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   botoes_debounced  : button levels, 1 = pressed
//   evento_ready      : consumer accepts the head event
//   evento_valid      : head event available
//   evento_idx        : index at the FIFO head (0 when empty)
//   pendentes         : some press is still waiting to enter the FIFO
// Optional build macro BOTOES_REPEAT_EN adds auto-repeat: while the button
// pattern is nonzero and stable, every REPEAT_TIME cycles all held buttons are
// marked pending again.
module botoes_event_encoder
  import botoes_pkg::*;
#(
  parameter int unsigned NUM_BOTOES  = NumBotoesDefault,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned REPEAT_TIME = 50000000
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_BOTOES-1:0]              botoes_debounced,
  input  logic                               evento_ready,
  output logic                               evento_valid,
  output logic [idx_width(NUM_BOTOES)-1:0]   evento_idx,
  output logic                               pendentes
);

  localparam int unsigned IdxW = idx_width(NUM_BOTOES);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (REPEAT_TIME == 0) begin : g_bad_repeat
    $error("REPEAT_TIME must be nonzero");
  end

  logic [NUM_BOTOES-1:0] prev_q;
  logic [NUM_BOTOES-1:0] pending_q, pending_d;
  logic [NUM_BOTOES-1:0] rise;
  logic [NUM_BOTOES-1:0] repeat_set;
  logic [IdxW-1:0]       low_idx;
  logic [IdxW-1:0]       head_idx;
  logic                  push, pop, full, empty;

  assign rise = botoes_debounced & ~prev_q;

  // Lowest pending index wins: scan high to low so the last hit is the lowest.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_BOTOES - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = IdxW'(i);
    end
  end

  // Full FIFO stalls pushes; pending bits simply wait, so nothing is lost.
  assign push = !full && (|pending_q);
  assign pop  = evento_valid && evento_ready;

  // Clear first, then OR in new sets so a same-cycle rise re-arms the bit.
  always_comb begin
    pending_d = pending_q;
    if (push) pending_d[low_idx] = 1'b0;
    pending_d = pending_d | rise | repeat_set;
  end

  // prev resets high so buttons held through reset do not fire.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q    <= '1;
      pending_q <= '0;
    end else begin
      prev_q    <= botoes_debounced;
      pending_q <= pending_d;
    end
  end

`ifdef BOTOES_REPEAT_EN
  localparam int unsigned RepW = (REPEAT_TIME > 1) ? $clog2(REPEAT_TIME) : 1;

  logic [RepW-1:0] rep_cnt_q;
  logic            held, rep_hit;

  assign held       = (|botoes_debounced) && (botoes_debounced == prev_q);
  assign rep_hit    = held && (rep_cnt_q == RepW'(REPEAT_TIME - 1));
  assign repeat_set = rep_hit ? botoes_debounced : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_cnt_q <= '0;
    end else if (!held || rep_hit) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_q + RepW'(1);
    end
  end
`else
  assign repeat_set = '0;
`endif

  botoes_event_fifo #(
    .WIDTH (IdxW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (low_idx),
    .pop       (pop),
    .pop_data  (head_idx),
    .full      (full),
    .empty     (empty)
  );

  assign evento_valid = !empty;
  assign evento_idx   = evento_valid ? head_idx : '0;
  assign pendentes    = |pending_q;

endmodule

// File: tb/tb_botoes_event_encoder.sv
// Self-checking bench for botoes_event_encoder: directed vector table,
// hand-written multi-cycle sequences and a randomized run against a
// queue-based reference model.
module tb_botoes_event_encoder;

  localparam int NB    = 13;
  localparam int IW    = botoes_pkg::IdxWDefault;
  localparam int DEPTH = 4;
  localparam int RT    = 10;
`ifdef BOTOES_REPEAT_EN
  localparam bit RepOn = 1'b1;
`else
  localparam bit RepOn = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [NB-1:0] b;
  logic          ready;
  logic          valid;
  logic [IW-1:0] idx;
  logic          pend;

  int n_tests = 0;
  int n_fail  = 0;

  botoes_event_encoder #(
    .NUM_BOTOES  (NB),
    .FIFO_DEPTH  (DEPTH),
    .REPEAT_TIME (RT)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .botoes_debounced (b),
    .evento_ready     (ready),
    .evento_valid     (valid),
    .evento_idx       (idx),
    .pendentes        (pend)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference model: pending presses as a bit set, the FIFO as a queue.
  bit [NB-1:0] m_prev;
  bit [NB-1:0] m_pend;
  int          m_q[$];
  int          m_run;

  task automatic model_init();
    m_prev = '1;
    m_pend = '0;
    m_q.delete();
    m_run = 0;
  endtask

  task automatic model_step(input bit [NB-1:0] bin, input bit rdy);
    bit [NB-1:0] rise, rep;
    bit          do_pop, do_push;
    int          low;
    do_pop  = (m_q.size() != 0) && rdy;
    do_push = (m_q.size() < DEPTH) && (m_pend != 0);
    low = -1;
    for (int i = 0; i < NB; i++) if (m_pend[i] && low < 0) low = i;
    rise = bin & ~m_prev;
    rep  = '0;
    if (RepOn) begin
      if (bin != 0 && bin == m_prev) m_run++;
      else m_run = 0;
      if (m_run > 0 && (m_run % RT) == 0) rep = bin;
    end
    if (do_pop) void'(m_q.pop_front());
    if (do_push) begin
      m_q.push_back(low);
      m_pend[low] = 1'b0;
    end
    m_pend = m_pend | rise | rep;
    m_prev = bin;
  endtask

  typedef struct {
    logic [NB-1:0] b;
    logic          rdy;
    logic          v;
    int            idx;
    logic          p;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [NB-1:0] bit_of(input int i);
    logic [NB-1:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  initial begin
    int          got[$];
    int          ev_cyc[$];
    int          cnt, last;
    int          exp_order[5];
    logic [NB-1:0] m;

    // Single press of 5, then 0/2/9 together; ready held high.
    vecs[0]  = '{b: '0,                              rdy: 1, v: 0, idx: 0, p: 0};
    vecs[1]  = '{b: bit_of(5),                       rdy: 1, v: 0, idx: 0, p: 1};
    vecs[2]  = '{b: bit_of(5),                       rdy: 1, v: 1, idx: 5, p: 0};
    vecs[3]  = '{b: bit_of(5),                       rdy: 1, v: 0, idx: 0, p: 0};
    vecs[4]  = '{b: bit_of(5),                       rdy: 1, v: 0, idx: 0, p: 0};
    vecs[5]  = '{b: '0,                              rdy: 1, v: 0, idx: 0, p: 0};
    vecs[6]  = '{b: bit_of(0)|bit_of(2)|bit_of(9),   rdy: 1, v: 0, idx: 0, p: 1};
    vecs[7]  = '{b: bit_of(0)|bit_of(2)|bit_of(9),   rdy: 1, v: 1, idx: 0, p: 1};
    vecs[8]  = '{b: bit_of(0)|bit_of(2)|bit_of(9),   rdy: 1, v: 1, idx: 2, p: 1};
    vecs[9]  = '{b: bit_of(0)|bit_of(2)|bit_of(9),   rdy: 1, v: 1, idx: 9, p: 0};
    vecs[10] = '{b: bit_of(0)|bit_of(2)|bit_of(9),   rdy: 1, v: 0, idx: 0, p: 0};
    vecs[11] = '{b: '0,                              rdy: 1, v: 0, idx: 0, p: 0};

    b = '0;
    ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    check("reset_valid", int'(valid), 0);
    check("reset_idx", int'(idx), 0);
    check("reset_pend", int'(pend), 0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      b = vecs[i].b;
      ready = vecs[i].rdy;
      tick();
      check($sformatf("tbl%0d_valid", i), int'(valid), int'(vecs[i].v));
      check($sformatf("tbl%0d_idx", i), int'(idx), vecs[i].idx);
      check($sformatf("tbl%0d_pend", i), int'(pend), int'(vecs[i].p));
    end

    // Full FIFO with ready low: 1..4 queued, 6 left pending, then drain.
    ready = 1'b0;
    b = bit_of(1) | bit_of(2) | bit_of(3) | bit_of(4) | bit_of(6);
    for (int k = 0; k < 8; k++) tick();
    check("full_valid", int'(valid), 1);
    check("full_head", int'(idx), 1);
    check("full_pend", int'(pend), 1);
    b = '0;
    ready = 1'b1;
    got.delete();
    for (int k = 0; k < 20; k++) begin
      if (valid && ready) got.push_back(int'(idx));
      tick();
    end
    exp_order = '{1, 2, 3, 4, 6};
    check("drain_count", got.size(), 5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("drain%0d_idx", k), (k < got.size()) ? got[k] : -1, exp_order[k]);
    end
    check("drain_pend", int'(pend), 0);

    // Asynchronous reset mid-operation discards queued and pending events.
    ready = 1'b0;
    b = bit_of(0) | bit_of(1) | bit_of(11);
    for (int k = 0; k < 3; k++) tick();
    check("pre_areset_valid", int'(valid), 1);
    #2;
    reset = 1'b1;
    #1;
    check("areset_valid", int'(valid), 0);
    check("areset_idx", int'(idx), 0);
    check("areset_pend", int'(pend), 0);
    tick();
    reset = 1'b0;
    b = '0;
    ready = 1'b1;
    tick();
    tick();

    // Button held through reset gives no event until re-pressed.
    b = bit_of(7);
    do_reset();
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (valid || pend) cnt++;
    end
    check("held_reset_quiet", cnt, 0);
    b = '0;
    tick();
    b = bit_of(7);
    cnt = 0;
    last = -1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (valid && ready) begin
        cnt++;
        last = int'(idx);
      end
    end
    check("repress_count", cnt, 1);
    check("repress_idx", last, 7);
    b = '0;
    for (int k = 0; k < 3; k++) tick();

    // Hold button 3 for 35 cycles: repeats only when the feature is built in.
    b = bit_of(3);
    ev_cyc.delete();
    cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 36) b = '0;
      tick();
      if (valid && ready) begin
        ev_cyc.push_back(k);
        if (int'(idx) != 3) cnt++;
      end
    end
    check("hold_event_count", ev_cyc.size(), RepOn ? 4 : 1);
    check("hold_wrong_idx", cnt, 0);
    check("hold_first_cycle", (ev_cyc.size() > 0) ? ev_cyc[0] : -1, 2);
    for (int k = 1; k < ev_cyc.size(); k++) begin
      check($sformatf("hold_gap%0d", k), ev_cyc[k] - ev_cyc[k-1], RT);
    end

    // Randomized run against the reference model.
    b = '0;
    ready = 1'b1;
    do_reset();
    model_init();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        m = NB'($urandom & $urandom & $urandom);
        b = m;
      end
      ready = ((c % 200) < 40) ? 1'b0 : ($urandom_range(0, 3) != 0);
      model_step(b, ready);
      tick();
      check("rnd_valid", int'(valid), (m_q.size() != 0) ? 1 : 0);
      check("rnd_idx", int'(idx), (m_q.size() != 0) ? m_q[0] : 0);
      check("rnd_pend", int'(pend), (m_pend != 0) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
